// File: rtl/scalar_multiply_mat_seq_pkg.sv
// Shared types and sizing helpers for the sequential matrix-by-scalar multiplier.
package scalar_mat_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } smul_state_t;

    // Row/column counter width: wide enough for the larger matrix dimension.
    function automatic int cnt_width(input int size_a, input int size_b);
        int m;
        m = (size_a > size_b) ? size_a : size_b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/scalar_multiply_mat_seq_mul_sat_stage.sv
// Two-stage unsigned multiply / shift / saturate pipeline.
// Stage 1 registers the full-width product; stage 2 is the combinational
// shift and clamp whose result the caller registers into its destination.
module mul_sat_stage #(
    parameter int N_BITS    = 22,
    parameter int FRAC_BITS = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    output logic              out_valid,
    output logic [N_BITS-1:0] out_val,
    output logic              out_sat
);

    logic [2*N_BITS-1:0] a_ext;
    logic [2*N_BITS-1:0] b_ext;
    logic [2*N_BITS-1:0] prod_q;
    logic [2*N_BITS-1:0] shifted;
    logic                valid_q;

    assign a_ext = {{N_BITS{1'b0}}, a};
    assign b_ext = {{N_BITS{1'b0}}, b};

    // Stage 1: capture the full product so no bits are lost before the shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            prod_q  <= '0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                prod_q <= a_ext * b_ext;
            end
        end
    end

    // Stage 2: drop fractional bits, clamp to all-ones if the upper half is nonzero.
    always_comb begin
        shifted   = prod_q >> FRAC_BITS;
        out_valid = valid_q;
        out_sat   = valid_q & (|shifted[2*N_BITS-1:N_BITS]);
        out_val   = out_sat ? {N_BITS{1'b1}} : shifted[N_BITS-1:0];
    end

endmodule

// File: rtl/scalar_multiply_mat_seq.sv
// Sequential element-wise matrix-by-scalar multiplier with saturation.
// One shared multiplier walks the matrix in row-major order under a
// start/busy/done handshake; operands are latched on the accepted start.
module scalar_multiply_mat_seq
    import scalar_mat_pkg::*;
#(
    parameter int SIZE_A    = 8,
    parameter int SIZE_B    = 8,
    parameter int N_BITS    = 22,
    parameter int FRAC_BITS = 0
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    input  logic [N_BITS-1:0]                          scale,
    input  logic [SIZE_A-1:0][SIZE_B-1:0][N_BITS-1:0]  matrix,
    output logic [SIZE_A-1:0][SIZE_B-1:0][N_BITS-1:0]  out_matrix,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       ovf
);

    localparam int CW = cnt_width(SIZE_A, SIZE_B);

    smul_state_t                              state;
    logic [N_BITS-1:0]                        scale_q;
    logic [SIZE_A-1:0][SIZE_B-1:0][N_BITS-1:0] mat_q;
    logic [CW-1:0]                            row;
    logic [CW-1:0]                            col;
    logic [CW-1:0]                            wr_row;
    logic [CW-1:0]                            wr_col;
    logic                                     accept;
    logic                                     issue;
    logic                                     last_col;
    logic                                     last_idx;
    logic                                     res_valid;
    logic [N_BITS-1:0]                        res_val;
    logic                                     res_sat;

    assign accept   = (state == IDLE) && start;
    assign issue    = (state == RUN);
    assign last_col = (col == CW'(SIZE_B - 1));
    assign last_idx = last_col && (row == CW'(SIZE_A - 1));
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // Sequencer: RUN issues one element per cycle, DRAIN waits for the final write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start)     state <= RUN;
                RUN:     if (last_idx)  state <= DRAIN;
                DRAIN:   if (res_valid) state <= DONE;
                DONE:                   state <= IDLE;
                default:                state <= IDLE;
            endcase
        end
    end

    // Operand capture and row-major index walk; write address trails by one stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scale_q <= '0;
            mat_q   <= '0;
            row     <= '0;
            col     <= '0;
            wr_row  <= '0;
            wr_col  <= '0;
        end else if (accept) begin
            scale_q <= scale;
            mat_q   <= matrix;
            row     <= '0;
            col     <= '0;
        end else if (issue) begin
            wr_row <= row;
            wr_col <= col;
            if (last_idx) begin
                row <= '0;
                col <= '0;
            end else if (last_col) begin
                row <= row + CW'(1);
                col <= '0;
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    mul_sat_stage #(
        .N_BITS    (N_BITS),
        .FRAC_BITS (FRAC_BITS)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (issue),
        .a         (mat_q[row][col]),
        .b         (scale_q),
        .out_valid (res_valid),
        .out_val   (res_val),
        .out_sat   (res_sat)
    );

    // Result matrix and per-run sticky overflow; entries hold between runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_matrix <= '0;
            ovf        <= 1'b0;
        end else begin
            if (accept) begin
                ovf <= 1'b0;
            end
            if (res_valid) begin
                out_matrix[wr_row][wr_col] <= res_val;
                if (res_sat) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scalar_multiply_mat_seq.sv
// Directed bench for scalar_multiply_mat_seq with a scoreboard queue of
// expected element values pushed at launch and popped after done.
module tb_scalar_multiply_mat_seq;

    localparam int SA = 8;
    localparam int SB = 8;
    localparam int NB = 22;
    localparam logic [2*NB-1:0] MAXV = {{NB{1'b0}}, {NB{1'b1}}};

    typedef logic [SA-1:0][SB-1:0][NB-1:0] mat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          start1 = 1'b0;
    logic [NB-1:0] scale = '0;
    logic [NB-1:0] scale1 = '0;
    mat_t          matrix = '0;
    mat_t          matrix1 = '0;
    mat_t          out_matrix;
    mat_t          out_matrix1;
    logic          busy, done, ovf;
    logic          busy1, done1, ovf1;

    int            n_vec = 0;
    int            n_err = 0;
    logic [NB-1:0] sb_q[$];

    always #5 clk = ~clk;

    scalar_multiply_mat_seq #(
        .SIZE_A(SA), .SIZE_B(SB), .N_BITS(NB), .FRAC_BITS(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .scale(scale), .matrix(matrix),
        .out_matrix(out_matrix), .busy(busy), .done(done), .ovf(ovf)
    );

    scalar_multiply_mat_seq #(
        .SIZE_A(SA), .SIZE_B(SB), .N_BITS(NB), .FRAC_BITS(8)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .scale(scale1), .matrix(matrix1),
        .out_matrix(out_matrix1), .busy(busy1), .done(done1), .ovf(ovf1)
    );

    function automatic logic [NB-1:0] model(input logic [NB-1:0] m, input logic [NB-1:0] s,
                                            input int frac);
        logic [2*NB-1:0] p;
        p = {{NB{1'b0}}, m} * {{NB{1'b0}}, s};
        p = p >> frac;
        if (p > MAXV) return {NB{1'b1}};
        return p[NB-1:0];
    endfunction

    function automatic mat_t fill(input logic [NB-1:0] v);
        mat_t m;
        for (int r = 0; r < SA; r++)
            for (int c = 0; c < SB; c++)
                m[r][c] = v;
        return m;
    endfunction

    function automatic mat_t ramp();
        mat_t m;
        for (int r = 0; r < SA; r++)
            for (int c = 0; c < SB; c++)
                m[r][c] = NB'(8 * r + c);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input mat_t m, input logic [NB-1:0] s, input int frac);
        for (int r = 0; r < SA; r++)
            for (int c = 0; c < SB; c++)
                sb_q.push_back(model(m[r][c], s, frac));
    endtask

    task automatic check_out(input string tag, input mat_t o);
        logic [NB-1:0] e;
        for (int r = 0; r < SA; r++) begin
            for (int c = 0; c < SB; c++) begin
                if (sb_q.size() == 0) begin
                    chk({tag, "_sb_empty"}, 64'd1, 64'd0);
                    return;
                end
                e = sb_q.pop_front();
                chk($sformatf("%s[%0d][%0d]", tag, r, c), o[r][c], e);
            end
        end
    endtask

    // Drives operands and start in an IDLE cycle; returns #1 after the accepting edge E0.
    task automatic launch(input mat_t m, input logic [NB-1:0] s);
        @(negedge clk);
        matrix = m;
        scale  = s;
        start  = 1'b1;
        push_exp(m, s, 0);
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_at_e0", busy, 64'd1);
    endtask

    // Counts edges after E0 until done; optionally injects a start plus operand change.
    task automatic wait_done(input string tag, input int inject_at);
        int lat;
        bit busy_ok;
        lat = 0;
        busy_ok = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            if (i == inject_at) begin
                start  = 1'b1;
                scale  = 22'd7;
                matrix = fill(22'h155555);
            end
            if (i == inject_at + 1) start = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        chk({tag, "_latency"}, lat, 64'd65);
        chk({tag, "_busy_run"}, busy_ok, 64'd1);
        chk({tag, "_busy_done"}, busy, 64'd1);
    endtask

    task automatic finish_run(input string tag, input logic exp_ovf);
        chk({tag, "_ovf"}, ovf, exp_ovf);
        check_out(tag, out_matrix);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, done, 64'd0);
        chk({tag, "_busy_after"}, busy, 64'd0);
    endtask

    initial begin
        mat_t m;
        int   lat1;
        bit   seen;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 64'd0);
        chk("rst_done", done, 64'd0);
        chk("rst_ovf", ovf, 64'd0);
        chk("rst_out_zero", (out_matrix == '0), 64'd1);
        @(negedge clk) rst_n = 1'b1;

        // uniform 3 * 5
        launch(fill(22'd3), 22'd5);
        wait_done("t1", 0);
        finish_run("t1", 1'b0);

        // single saturating element, then scale 1 clears ovf
        m = fill(22'd1);
        m[2][5] = 22'h200000;
        launch(m, 22'd4);
        wait_done("t2", 0);
        finish_run("t2", 1'b1);
        launch(m, 22'd1);
        chk("t2b_ovf_cleared_at_start", ovf, 64'd0);
        wait_done("t2b", 0);
        finish_run("t2b", 1'b0);

        // ramp * 2 with ignored start and operand change mid-run
        launch(ramp(), 22'd2);
        wait_done("t3", 20);
        finish_run("t3", 1'b0);

        // reset mid-run aborts cleanly
        launch(ramp(), 22'd9);
        repeat (29) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("t4_rst_busy", busy, 64'd0);
        chk("t4_rst_done", done, 64'd0);
        chk("t4_rst_out_zero", (out_matrix == '0), 64'd1);
        sb_q.delete();
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("t4_no_done", seen, 64'd0);
        chk("t4_out_still_zero", (out_matrix == '0), 64'd1);
        launch(ramp(), 22'd3);
        wait_done("t4b", 0);
        finish_run("t4b", 1'b0);

        // scale 0 after nonzero run, then start held from DONE into first IDLE cycle
        launch(ramp(), 22'd0);
        wait_done("t5", 0);
        chk("t5_ovf", ovf, 64'd0);
        check_out("t5", out_matrix);
        m      = fill(22'd1000);
        matrix = m;
        scale  = 22'd3;
        start  = 1'b1;
        push_exp(m, 22'd3, 0);
        @(posedge clk);
        #1;
        chk("t5_start_in_done_ignored", busy, 64'd0);
        chk("t5_done_pulse", done, 64'd0);
        @(posedge clk);
        #1 start = 1'b0;
        chk("t6_accepted_first_idle", busy, 64'd1);
        wait_done("t6", 0);
        finish_run("t6", 1'b0);

        // fractional instance
        m = fill(22'h000200);
        m[0][1] = 22'h000201;
        push_exp(m, 22'h000180, 8);
        @(negedge clk);
        matrix1 = m;
        scale1  = 22'h000180;
        start1  = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        lat1 = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done1) begin
                lat1 = i;
                break;
            end
        end
        chk("t7_latency", lat1, 64'd65);
        chk("t7_ovf", ovf1, 64'd0);
        check_out("t7", out_matrix1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
